i2c_master_seq: RTL
===================

Name: i2c_master_seq

Overview:
- Command-driven I2C master for the 25 MHz domain. Sequences register-write and register-read transactions against an 8-bit-register slave such as i2c_internal.
- Write sequence: START, dev+W, reg, data, STOP. Read sequence: START, dev+W, reg, repeated START, dev+R, 1 byte with master NACK, STOP.
- Bus pins are open-drain enables; pads and pull-ups sit outside the block.

Parameters:
- QTR_DIV, 31: clk_25 cycles per SCL quarter-period, minus 1. SCL period = 4*(QTR_DIV+1) cycles; the default gives 5.12 us at 25 MHz.
- QW, 8: width of the quarter counter. QTR_DIV must be < 2**QW.

Ports:
- clk_25  in  1  system clock, 25 MHz
- reset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  0=write, 1=read
- cmd_dev  in  7  slave address
- cmd_reg  in  8  register address
- cmd_wdata  in  8  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte; 0 for writes and NACK aborts
- rsp_nack  out  1  slave NACKed a byte
- busy  out  1  transaction in progress
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- scl_in  in  1  SCL pad level
- sda_in  in  1  SDA pad level (synchronised externally)

Behaviour:
- Reset (async, immediate): scl_oe=0 and sda_oe=0 (bus released), cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, state=IDLE, all counters 0.
- Reset mid-transfer releases the bus in the same instant. No bus recovery is attempted.
- Handshake: a command is accepted on the cycle where cmd_valid & cmd_ready. All cmd_* fields are latched on that cycle. busy rises the next cycle.
- Quarter tick: qtick pulses every QTR_DIV+1 cycles, only while busy. The counter restarts on accept.
- States: IDLE, START, BIT, ACK, RSTART, STOP, DONE.
- START, 4 quarters: q0 SDA=rel, SCL=rel; q1 no change; q2 SDA low; q3 SCL low.
- BIT, 4 quarters per bit, MSB first: q0 SCL low and SDA set from shift[7] (or released when reading); q1 hold; q2 SCL released; q3 hold.
- BIT sampling: SDA is sampled into shift[0] on the last cycle of q3; SCL is pulled low on the following q0.
- ACK: the master releases SDA when checking a slave ACK. When reading, it drives sda_oe=0 (NACK). ACK is sampled at the same point as a data bit.
- Byte index: 0=dev+W, 1=reg, 2=wdata (write) or dev+R (read), 3=read data.
- After the byte-1 ACK of a read, the sequencer goes to RSTART.
- RSTART: q0 SDA rel, SCL low; q1 SCL rel; q2 SDA low; q3 SCL low. Then byte 2 = {cmd_dev,1}.
- NACK (sda_in=1) on any master-written byte: skip remaining bytes, go to STOP, set rsp_nack=1, rsp_rdata=0.
- STOP: q0 SDA low; q1 SCL rel; q2 hold; q3 SDA rel. Then DONE.
- DONE: rsp_valid=1 for exactly 1 cycle, then IDLE and cmd_ready=1 in the next cycle. rsp_rdata and rsp_nack hold until the next rsp_valid.
- Latency: a write with all ACKs takes 4+3*36+4 = 116 quarters; a read takes 4+2*36+4+2*36+4 = 156 quarters. Each is followed by 1 DONE cycle.
- cmd_valid while busy: ignored, not queued. The requester must hold it.
- scl_oe and sda_oe are registered outputs: no glitches, and they change only on qtick boundaries.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: in BIT, ACK and RSTART q2, the quarter counter holds while scl_in=0 after release, so slave stretching is honoured. No timeout.
- Undefined: scl_in is unused and timing is purely counter-based.

Decomposition:
- Shared package: state encoding localparams, byte-index constants, the ACK/NACK constants (ACK=0, NACK=1) and the default QTR_DIV.
- Sub-module i2c_qtick: the quarter-tick divider with enable and sync restart. Everything else stays in one module.

Test Plan:
- Write: dev=0x77, reg=0x05, wdata=0x06 into i2c_internal #(7'h77,'h52). Expect 3 ACKs, rsp_valid with rsp_nack=0, and reg_memory[5]=0x06.
- Loop: writes to regs 0x00..0x0F with data reg+1, then reads of 0x00..0x0F. Expect rsp_rdata = reg+1 each time, and an SCL period of 128 cycles.
- Wrong address: dev=0x22. Expect NACK on byte 0, a STOP immediately after, rsp_nack=1, rsp_rdata=0, and exactly 9 SCL pulses.
- Overlap: cmd_valid held through a write. Expect cmd_ready=0 while busy, the second command accepted 1 cycle after rsp_valid, and no lost or duplicated transaction.
- Async reset: reset asserted in the middle of byte 1, off a clock edge. Expect scl_oe=sda_oe=0 with no clock edge, busy=0, and a clean next transaction.
- With I2C_CLK_STRETCH_EN: the slave model holds SCL low for 300 cycles on bit 3 of byte 1. Expect the high phase delayed 300 cycles and correct data.

Source files
------------

// File: rtl/i2c_master_seq_pkg.sv
// Shared encodings for the I2C register-access master: states, byte indices,
// ACK/NACK bus levels and the default SCL quarter divider.
package i2c_master_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_RSTART, S_STOP, S_DONE
  } state_e;

  localparam int QTR_DIV_DEF = 31;

  localparam logic [1:0] B_DEVW = 2'd0;  // dev + W
  localparam logic [1:0] B_REG  = 2'd1;
  localparam logic [1:0] B_DATA = 2'd2;  // wdata, or dev + R when reading
  localparam logic [1:0] B_RDAT = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_qtick.sv
// SCL quarter-period divider: one-cycle tick every QTR_DIV+1 enabled cycles,
// synchronous restart to zero. Holding en_i freezes the count.
module i2c_qtick #(
  parameter int QTR_DIV = 31,
  parameter int QW      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [QW-1:0] TOP = QW'(QTR_DIV);

  logic [QW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)  cnt_d = '0;
    else if (en_i)  cnt_d = (cnt_q == TOP) ? '0 : cnt_q + QW'(1);
  end

  assign tick_o = en_i & ~restart_i & (cnt_q == TOP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Command-driven I2C master: register write (dev+W, reg, data) and register
// read (dev+W, reg, Sr, dev+R, data+NACK). Define I2C_CLK_STRETCH_EN to
// honour slave clock stretching during the SCL-high quarter.
module i2c_master_seq
  import i2c_master_seq_pkg::*;
#(
  parameter int QTR_DIV = QTR_DIV_DEF,
  parameter int QW      = 8
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  state_e      state_q, state_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  shift_q, shift_d;
  logic        nack_q, nack_d;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdata_q;
  logic        scl_oe_q, sda_oe_q, scl_d, sda_d;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_nack_q;
  logic        accept, qtick, stretch_hold;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

`ifdef I2C_CLK_STRETCH_EN
  // Freeze the quarter while we have released SCL but the slave still holds it.
  assign stretch_hold = (state_q == S_BIT || state_q == S_ACK || state_q == S_RSTART) &&
                        (q_q == 2'd2) && !scl_oe_q && !scl_in;
`else
  logic scl_in_unused;
  assign scl_in_unused = scl_in;
  assign stretch_hold  = 1'b0;
`endif

  i2c_qtick #(.QTR_DIV(QTR_DIV), .QW(QW)) u_qtick (
    .clk_i     (clk_25),
    .rst_i     (reset),
    .en_i      (busy & ~stretch_hold),
    .restart_i (accept),
    .tick_o    (qtick)
  );

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      nack_q      <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      nack_q   <= nack_d;
      scl_oe_q <= scl_d;
      sda_oe_q <= sda_d;
      if (accept) begin
        rw_q    <= cmd_rw;
        dev_q   <= cmd_dev;
        reg_q   <= cmd_reg;
        wdata_q <= cmd_wdata;
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
        rsp_rdata_q <= (rw_q && !nack_q) ? shift_q : 8'h00;
        rsp_nack_q  <= nack_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    nack_d  = nack_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_START;
        q_d     = '0;
        bit_d   = '0;
        byte_d  = B_DEVW;
        shift_d = {cmd_dev, 1'b0};
        nack_d  = 1'b0;
      end
      S_DONE: state_d = S_IDLE;
      default: if (qtick) begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd3) begin
          case (state_q)
            S_START: state_d = S_BIT;
            S_BIT: begin
              shift_d = {shift_q[6:0], sda_in};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_ACK;
            end
            S_ACK: begin
              state_d = S_BIT;
              byte_d  = byte_q + 2'd1;
              if (byte_q != B_RDAT && sda_in == I2C_NACK) begin
                state_d = S_STOP;
                nack_d  = 1'b1;
              end else begin
                case (byte_q)
                  B_DEVW: shift_d = reg_q;
                  B_REG:  if (rw_q) state_d = S_RSTART; else shift_d = wdata_q;
                  B_DATA: if (rw_q) shift_d = 8'hFF; else state_d = S_STOP;
                  default: state_d = S_STOP;
                endcase
              end
            end
            S_RSTART: begin
              state_d = S_BIT;
              shift_d = {dev_q, 1'b1};
            end
            S_STOP:  state_d = S_DONE;
            default: ;
          endcase
        end
      end
    endcase
  end

  // Pin levels for the quarter being entered; registered so they move only on ticks.
  always_comb begin
    scl_d = scl_oe_q;
    sda_d = sda_oe_q;
    if (qtick) begin
      case (state_d)
        S_START: begin
          if (q_d == 2'd2) sda_d = 1'b1;
          if (q_d == 2'd3) scl_d = 1'b1;
        end
        S_BIT: begin
          if (q_d == 2'd0) begin
            scl_d = 1'b1;
            sda_d = (rw_q && byte_d == B_RDAT) ? 1'b0 : ~shift_d[7];
          end
          if (q_d == 2'd2) scl_d = 1'b0;
        end
        S_ACK: begin
          if (q_d == 2'd0) begin scl_d = 1'b1; sda_d = 1'b0; end
          if (q_d == 2'd2) scl_d = 1'b0;
        end
        S_RSTART: begin
          if (q_d == 2'd0) begin scl_d = 1'b1; sda_d = 1'b0; end
          if (q_d == 2'd1) scl_d = 1'b0;
          if (q_d == 2'd2) sda_d = 1'b1;
          if (q_d == 2'd3) scl_d = 1'b1;
        end
        S_STOP: begin
          if (q_d == 2'd0) begin scl_d = 1'b1; sda_d = 1'b1; end
          if (q_d == 2'd1) scl_d = 1'b0;
          if (q_d == 2'd3) sda_d = 1'b0;
        end
        default: begin scl_d = 1'b0; sda_d = 1'b0; end
      endcase
    end
  end

endmodule
